// File: rtl/one_hot_arbiter.sv
// Round-robin arbiter producing the registered one-hot mux select.
// Grants are held per transfer; every owner change passes one idle cycle.
module one_hot_arbiter #(
  parameter int CHANNELS = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] reqIn,
  input  logic                doneIn,
  output logic [CHANNELS-1:0] selOneHot,
  output logic                grantValid,
  output logic [IDX_W-1:0]    grantIndex,
  output logic                timeoutPulse
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                tp_q, tp_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;

  logic [CHANNELS-1:0] win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  int                  scan;

  // Circular priority scan starting at the pointer.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    scan    = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= CHANNELS) scan = scan - CHANNELS;
      if (!win_any && |(reqIn & (CHANNELS'(1) << scan))) begin
        win_any = 1'b1;
        win_oh  = CHANNELS'(1) << scan;
        win_idx = IDX_W'(scan);
      end
    end
  end

  logic           owner_req;
  logic           to_hit;
  logic           release_now;
  logic [IDX_W-1:0] ptr_nxt;
  int             nxt;

  always_comb begin
    owner_req   = |(reqIn & sel_q);
    to_hit      = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    release_now = doneIn || !owner_req || to_hit;
    nxt         = int'(idx_q) + 1;
    if (nxt >= CHANNELS) nxt = 0;
    ptr_nxt     = IDX_W'(nxt);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tp_d    = 1'b0;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (win_any) begin
          sel_d   = win_oh;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = BUSY;
        end else begin
          sel_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (release_now) begin
          sel_d   = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          ptr_d   = ptr_nxt;
          state_d = GAP;
          tp_d    = to_hit && !doneIn && owner_req;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        sel_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tp_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tp_q    <= tp_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign selOneHot    = sel_q;
  assign grantValid   = valid_q;
  assign grantIndex   = idx_q;
  assign timeoutPulse = tp_q;

endmodule

// File: doc/one_hot_arbiter.md
Name: one_hot_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the channel mux. It takes a request vector from CHANNELS sources and produces the registered one-hot select that drives the mux select input, plus status outputs. A grant is held for the whole transfer. It is released on done, on request withdrawal, or on a hold timeout. Priority then rotates past the last owner, and every grant change passes through exactly one all-zero cycle so the mux never switches sources mid-beat.

Parameters:
CHANNELS, 4, number of requesters; must be >= 2; equals the mux channel count.
MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant; 0 disables the timeout.
IDX_W, 2, width of grantIndex; must satisfy 2**IDX_W >= CHANNELS.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  system reset; asynchronous, active-high.
reqIn  input  CHANNELS  request per source; bit i = source i wants the mux.
doneIn  input  1  current owner's transfer finished; sampled only in BUSY.
selOneHot  output  CHANNELS  registered one-hot grant; drives the mux select; all-zero = no owner.
grantValid  output  1  registered; equals OR of selOneHot.
grantIndex  output  IDX_W  registered binary index of the owner; 0 when no owner.
timeoutPulse  output  1  registered; one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - selOneHot=0, grantValid=0, grantIndex=0, timeoutPulse=0.
  - Priority pointer=0, hold counter=0, state=IDLE.
  - Reset mid-grant clears the grant immediately, without waiting for a clock edge.
- States: IDLE, BUSY, GAP.
- Arbitration function:
  - Scan reqIn circularly starting at the pointer: ptr, ptr+1, ..., wrapping modulo CHANNELS.
  - The first set bit wins.
  - The result is always one-hot or zero; selOneHot never has more than one bit set.
- IDLE:
  - If reqIn != 0, register the winner into selOneHot/grantIndex, set grantValid=1, clear the hold counter, and go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
  - Latency: request present at edge N -> grant visible after edge N (cycle N+1).
- BUSY:
  - selOneHot is held constant. reqIn changes by other sources are ignored.
  - The hold counter increments every cycle and saturates.
  - Release condition (evaluated at each edge): doneIn=1, OR the owner's reqIn bit=0, OR (MAX_HOLD!=0 AND hold counter==MAX_HOLD-1).
  - On release: clear selOneHot/grantValid/grantIndex, set pointer=(owner index+1) mod CHANNELS, go to GAP.
  - If the release is caused only by the timeout (doneIn=0 and owner still requesting), assert timeoutPulse for that one cycle.
  - If doneIn and the timeout coincide, there is no timeoutPulse.
- GAP:
  - Outputs are zero for exactly one cycle.
  - At the next edge, arbitrate using the updated pointer: on a winner go to BUSY with the new grant, else go to IDLE.
  - Result: back-to-back owners are separated by exactly one zero cycle.
- Pointer wrap: owner CHANNELS-1 -> pointer 0.
- Fairness: a continuously requesting source is granted within CHANNELS grant cycles.
- doneIn outside BUSY is ignored.
- An owner that re-requests is eligible again, but only after all requesters between pointer and owner have been considered.
- timeoutPulse is 0 in every cycle except the one following a forced release.
- No combinational path from reqIn/doneIn to any output.

Test Plan:
- Reset/idle: assert reset mid-BUSY with selOneHot=0100 -> selOneHot=0000, grantValid=0, grantIndex=0 immediately, before the next clk edge; state IDLE after release.
- Single request: reqIn=0010 at edge N -> selOneHot=0010, grantIndex=1 at N+1; doneIn pulse at edge M -> selOneHot=0000 at M+1 (GAP), 0000 at M+2 (IDLE).
- Round-robin: reqIn=1111 held, doneIn pulsed on every 3rd BUSY cycle -> grant order 0001,0010,0100,1000,0001, each separated by one 0000 cycle.
- Wrap/skip: pointer=3 (last owner 2), reqIn=0101 -> grant 0001 (source 0), then 0100.
- Timeout: MAX_HOLD=16, reqIn=0001 held, doneIn=0 -> grant high for 16 cycles, then 0000 with timeoutPulse=1 for exactly one cycle; regrant to source 0 follows because it is the only requester.
- Withdrawal and coincidence: owner drops its req in BUSY -> release next edge, no timeoutPulse; doneIn=1 on the timeout cycle -> release with timeoutPulse=0; selOneHot is checked one-hot-or-zero on every cycle.
